bram_mac_engine: RTL



---
 rtl/bram_mac_engine.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/bram_mac_engine.sv
`default_nettype none
// ============================================================================
//  Module   : bram_mac_engine
//  Purpose  : Two on-chip operand memories (A, B) loaded through a write port.
//             A start request streams len operand pairs through a registered
//             multiplier. The engine emits one product per element (mode 0)
//             or a single accumulated dot product (mode 1).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        rising-edge clock
//    rst        synchronous active-high reset
//    wr_en      operand write strobe (honoured in IDLE and DONE only)
//    wr_sel     0 = memory A, 1 = memory B
//    wr_addr    write address
//    wr_data    write data
//    start      run request, sampled only in IDLE
//    len        element count, clamped to DEPTH
//    mode       0 = element-wise products, 1 = dot-product accumulate
//    busy       high from the first RUN cycle through the DONE cycle
//    done       one-cycle completion pulse
//    out_valid  qualifier for out_data / out_idx
//    out_idx    element index of out_data (0 in mode 1)
//    out_data   extended product, or the accumulated sum
// ============================================================================
module bram_mac_engine #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int SIGNED = 0,
    parameter int OUT_W  = 2*DATA_W + ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_idx,
    output logic [OUT_W-1:0]  out_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    // Operand memories; contents are not reset
    logic [DATA_W-1:0] r_mem_a [DEPTH];
    logic [DATA_W-1:0] r_mem_b [DEPTH];

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_next;
    logic [ADDR_W:0]   r_last;
    logic              r_mode;
    logic              r_drain;

    logic [DATA_W-1:0] r_rd_a;
    logic [DATA_W-1:0] r_rd_b;
    logic [2*DATA_W-1:0] w_prod_full;
    logic [OUT_W-1:0]  w_prod;

    logic              r_p_valid;
    logic [ADDR_W-1:0] r_p_idx;
    logic [OUT_W-1:0]  r_prod;
    logic [OUT_W-1:0]  r_acc;

    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_idx;
    logic [OUT_W-1:0]  r_out_data;

    logic              w_accept;
    logic [ADDR_W:0]   w_len_c;
    logic              w_wr_ok;
    logic              w_enter_done;
    logic              w_run_mode;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_len_c    = (len > c_depth) ? c_depth : len;
    assign w_wr_ok    = wr_en && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_run_mode = w_accept ? mode : r_mode;
    assign w_enter_done = (r_state != S_DONE) && (w_state_next == S_DONE);

    // ------------------------------------------------------------------
    // Next-state and read-address generation. The memory is read with the
    // next counter value so that element k's operands are registered at
    // the edge entering RUN cycle k; element 0 is therefore read on the
    // acceptance edge itself, before a same-edge write to address 0 lands.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (w_len_c == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_cnt_next = r_cnt + 1'b1;
                if ({1'b0, r_cnt} == r_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Full-width product, extended to the result width
    // ------------------------------------------------------------------
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_prod_full = {{DATA_W{r_rd_a[DATA_W-1]}}, r_rd_a}
                               * {{DATA_W{r_rd_b[DATA_W-1]}}, r_rd_b};
            assign w_prod = {{(OUT_W-2*DATA_W){w_prod_full[2*DATA_W-1]}}, w_prod_full};
        end else begin : g_unsigned
            assign w_prod_full = {{DATA_W{1'b0}}, r_rd_a} * {{DATA_W{1'b0}}, r_rd_b};
            assign w_prod = {{(OUT_W-2*DATA_W){1'b0}}, w_prod_full};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Operand memories with registered read
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            if (wr_sel) begin
                r_mem_b[wr_addr] <= wr_data;
            end else begin
                r_mem_a[wr_addr] <= wr_data;
            end
        end
        r_rd_a <= r_mem_a[w_cnt_next];
        r_rd_b <= r_mem_b[w_cnt_next];
    end

    // ------------------------------------------------------------------
    // Control, product stage, accumulator and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last      <= '0;
            r_mode      <= 1'b0;
            r_drain     <= 1'b0;
            r_p_valid   <= 1'b0;
            r_p_idx     <= '0;
            r_prod      <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_drain <= (r_state == S_DRAIN) && !r_drain;

            // Operand registers hold element r_cnt during each RUN cycle
            r_p_valid <= (r_state == S_RUN);
            if (r_state == S_RUN) begin
                r_prod  <= w_prod;
                r_p_idx <= r_cnt;
            end

            if (r_p_valid && r_mode) begin
                r_acc <= r_acc + r_prod;
            end

            if (w_accept) begin
                r_mode <= mode;
                r_last <= w_len_c - 1'b1;
                r_acc  <= '0;
            end

            r_out_valid <= 1'b0;
            if (r_p_valid && !r_mode) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_prod;
                r_out_idx   <= r_p_idx;
            end
            // The final accumulation lands on the edge entering DRAIN's last
            // cycle, so the sum is complete when DONE is entered.
            if (w_enter_done && w_run_mode) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_accept ? '0 : r_acc;
                r_out_idx   <= '0;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire
